// File: rtl/hazard_scoreboard_if.sv
// Hazard scoreboard pipeline-control bundle: decode/execute status in, stall/flush/forward out.
// Ports: master drives the decode fields, pcsrcE and mem_busy; slave drives stall/flush/fwd/counters.
// Widths follow DEPTH, REG_ADDR_W and CNT_W, which must match the hazard_scoreboard instance.
interface hazard_scoreboard_if #(
  parameter int DEPTH      = 3,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  localparam int FWD_W = $clog2(DEPTH + 1);

  // Decode-stage instruction and pipeline status.
  logic                  issue_valid;
  logic [REG_ADDR_W-1:0] rs1D;
  logic [REG_ADDR_W-1:0] rs2D;
  logic [REG_ADDR_W-1:0] rdD;
  logic                  regwriteD;
  logic                  loadD;
  logic                  pcsrcE;
  logic                  mem_busy;

  // Hazard controls and operand source selects.
  logic                  stallF;
  logic                  stallD;
  logic                  flushD;
  logic                  flushE;
  logic [FWD_W-1:0]      fwd_a;
  logic [FWD_W-1:0]      fwd_b;
  logic [CNT_W-1:0]      stall_cnt;
  logic [CNT_W-1:0]      flush_cnt;

  modport master (
    output issue_valid, rs1D, rs2D, rdD, regwriteD, loadD, pcsrcE, mem_busy,
    input  stallF, stallD, flushD, flushE, fwd_a, fwd_b, stall_cnt, flush_cnt
  );

  modport slave (
    input  issue_valid, rs1D, rs2D, rdD, regwriteD, loadD, pcsrcE, mem_busy,
    output stallF, stallD, flushD, flushE, fwd_a, fwd_b, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Purpose: tracks in-flight destinations after decode; produces stall/flush/forward controls.
// Latency: stall/flush/forward outputs are combinational from scoreboard state and inputs; state moves 1 cycle/stage.
// Backpressure: mem_busy freezes the whole scoreboard and holds F/D; flushes are suppressed until it drops.
//
// Ports:
//   clk  - core clock, all state on rising edge
//   rst  - asynchronous active-low reset; clears entries and counters, forces all controls low
//   hz   - hazard_scoreboard_if.slave: decode fields, pcsrcE, mem_busy in; stallF/stallD,
//          flushD/flushE, fwd_a/fwd_b (0 = regfile, k = entry k-1), stall_cnt/flush_cnt out
// Optional feature: define HAZARD_PERF_CNT_EN to build the saturating stall/flush counters;
// without it the counter outputs are tied to zero and no counter flops exist.
module hazard_scoreboard #(
  parameter int DEPTH      = 3,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  hazard_scoreboard_if.slave hz
);
  localparam int FWD_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwrite;
    logic                  load;
  } entry_t;

  // Entry 0 = E, 1 = M, 2 = W (for the default depth).
  entry_t ent_q [DEPTH];
  entry_t ent_d [DEPTH];

  logic             stall_front;
  logic             stall_dec;
  logic             flush_dec;
  logic             flush_ex;
  logic             load_use;
  logic [DEPTH-1:0] fwd_ok;
  logic [FWD_W-1:0] fwd_a_c;
  logic [FWD_W-1:0] fwd_b_c;

  // A load still in E has no data yet, so it can never be a forwarding source.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      fwd_ok[k] = ent_q[k].valid && ent_q[k].regwrite && (ent_q[k].rd != '0)
                  && !((k == 0) && ent_q[k].load);
    end
  end

  // Scan from the oldest entry down so the youngest matching producer wins.
  always_comb begin
    fwd_a_c = '0;
    fwd_b_c = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (fwd_ok[k] && (ent_q[k].rd == hz.rs1D)) fwd_a_c = FWD_W'(k + 1);
      if (fwd_ok[k] && (ent_q[k].rd == hz.rs2D)) fwd_b_c = FWD_W'(k + 1);
    end
  end

  assign load_use = hz.issue_valid && ent_q[0].valid && ent_q[0].load && (ent_q[0].rd != '0)
                    && ((ent_q[0].rd == hz.rs1D) || (ent_q[0].rd == hz.rs2D));

  // Priority: reset > mem_busy freeze > taken branch > load-use.
  // A branch held across a freeze reappears unmasked in the first free cycle.
  always_comb begin
    stall_front = 1'b0;
    stall_dec   = 1'b0;
    flush_dec   = 1'b0;
    flush_ex    = 1'b0;
    if (!rst) begin
      stall_front = 1'b0;
    end else if (hz.mem_busy) begin
      stall_front = 1'b1;
      stall_dec   = 1'b1;
    end else if (hz.pcsrcE) begin
      flush_dec   = 1'b1;
      flush_ex    = 1'b1;
    end else if (load_use) begin
      stall_front = 1'b1;
      stall_dec   = 1'b1;
      flush_ex    = 1'b1;
    end
  end

  // Entry 0 takes the decode instruction only when it genuinely moves into E;
  // a stalled or flushed cycle injects a bubble, which also ends the load-use stall.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) ent_d[k] = ent_q[k];
    if (!hz.mem_busy) begin
      for (int k = 1; k < DEPTH; k++) ent_d[k] = ent_q[k-1];
      ent_d[0] = '0;
      if (hz.issue_valid && !stall_dec && !flush_dec && !flush_ex) begin
        ent_d[0].valid    = 1'b1;
        ent_d[0].rd       = hz.rdD;
        ent_d[0].regwrite = hz.regwriteD;
        ent_d[0].load     = hz.loadD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) ent_q[k] <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) ent_q[k] <= ent_d[k];
    end
  end

  assign hz.stallF = stall_front;
  assign hz.stallD = stall_dec;
  assign hz.flushD = flush_dec;
  assign hz.flushE = flush_ex;
  assign hz.fwd_a  = fwd_a_c;
  assign hz.fwd_b  = fwd_b_c;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d;

  // Counters stick at all-ones rather than wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_dec && !(&stall_cnt_q))             stall_cnt_d = stall_cnt_q + 1'b1;
    if ((flush_dec || flush_ex) && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;
`else
  assign hz.stall_cnt = {CNT_W{1'b0}};
  assign hz.flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Testbench for hazard_scoreboard (DEPTH=3, REG_ADDR_W=5, CNT_W=4).
// Expected outputs come from an in-order instruction list model of the pipeline.
// Counter expectations depend on whether HAZARD_PERF_CNT_EN is defined.
module tb_hazard_scoreboard;
  localparam int DEPTH      = 3;
  localparam int REG_ADDR_W = 5;
  localparam int CNT_W      = 4;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic clk;
  logic rst;

  hazard_scoreboard_if #(.DEPTH(DEPTH), .REG_ADDR_W(REG_ADDR_W), .CNT_W(CNT_W)) hz ();

  hazard_scoreboard #(.DEPTH(DEPTH), .REG_ADDR_W(REG_ADDR_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One in-flight instruction as the model sees it (index 0 = youngest, in E).
  typedef struct {
    bit v;
    int rd;
    bit rw;
    bit ld;
  } rec_t;

  typedef struct {
    int sf, sd, fd, fe, fa, fb, sc, fc;
    int cyc;
  } exp_t;

  rec_t pipe [$];
  exp_t exp_q [$];
  int   m_sc, m_fc;
  bit   m_last_stall;
  int   cyc;
  int   errors;
  int   checks;

  task automatic chk(input string nm, input logic [31:0] act, input int req, input int c);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", nm, c, act, req);
    end
  endtask

  // Monitor: the DUT presents a full set of controls every cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("stallF",    hz.stallF,    e.sf, e.cyc);
      chk("stallD",    hz.stallD,    e.sd, e.cyc);
      chk("flushD",    hz.flushD,    e.fd, e.cyc);
      chk("flushE",    hz.flushE,    e.fe, e.cyc);
      chk("fwd_a",     hz.fwd_a,     e.fa, e.cyc);
      chk("fwd_b",     hz.fwd_b,     e.fb, e.cyc);
      chk("stall_cnt", hz.stall_cnt, e.sc, e.cyc);
      chk("flush_cnt", hz.flush_cnt, e.fc, e.cyc);
    end
  end

  function automatic int sat(input int v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  function automatic bit can_fwd(input int i);
    return pipe[i].v && pipe[i].rw && (pipe[i].rd != 0) && !(i == 0 && pipe[i].ld);
  endfunction

  function automatic int src_of(input int r);
    for (int i = 0; i < DEPTH; i++)
      if (can_fwd(i) && pipe[i].rd == r) return i + 1;
    return 0;
  endfunction

  task automatic clear_model();
    rec_t b;
    b = '{v: 0, rd: 0, rw: 0, ld: 0};
    pipe.delete();
    for (int i = 0; i < DEPTH; i++) pipe.push_back(b);
    m_sc = 0;
    m_fc = 0;
    m_last_stall = 0;
  endtask

  // Drive one cycle of inputs, record what the DUT must show, then advance the model.
  task automatic step(input bit rn, input bit iv, input int r1, input int r2, input int rd,
                      input bit rw, input bit ld, input bit pc, input bit mb);
    exp_t e;
    rec_t n;
    bit   lu;
    @(posedge clk);
    #1;
    rst            = rn;
    hz.issue_valid = iv;
    hz.rs1D        = REG_ADDR_W'(r1);
    hz.rs2D        = REG_ADDR_W'(r2);
    hz.rdD         = REG_ADDR_W'(rd);
    hz.regwriteD   = rw;
    hz.loadD       = ld;
    hz.pcsrcE      = pc;
    hz.mem_busy    = mb;
    cyc++;
    e = '{sf: 0, sd: 0, fd: 0, fe: 0, fa: 0, fb: 0, sc: 0, fc: 0, cyc: cyc};
    if (!rn) begin
      clear_model();
    end else begin
      e.fa = src_of(r1);
      e.fb = src_of(r2);
      lu = iv && pipe[0].v && pipe[0].ld && pipe[0].rd != 0 && (pipe[0].rd == r1 || pipe[0].rd == r2);
      if (mb) begin
        e.sf = 1; e.sd = 1;
      end else if (pc) begin
        e.fd = 1; e.fe = 1;
      end else if (lu) begin
        e.sf = 1; e.sd = 1; e.fe = 1;
      end
`ifdef HAZARD_PERF_CNT_EN
      e.sc = m_sc;
      e.fc = m_fc;
`endif
      if (e.sd != 0) m_sc = sat(m_sc + 1);
      if (e.fd != 0 || e.fe != 0) m_fc = sat(m_fc + 1);
      if (!mb) begin
        n = '{v: 0, rd: 0, rw: 0, ld: 0};
        if (iv && e.sd == 0 && e.fd == 0 && e.fe == 0) n = '{v: 1, rd: rd, rw: rw, ld: ld};
        pipe.push_front(n);
        void'(pipe.pop_back());
      end
      m_last_stall = (e.sd != 0);
    end
    exp_q.push_back(e);
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bit iv, rw, ld, pc, mb, rn, prev_mb, prev_pc;
    int r1, r2, rd, wait_cnt;
    errors = 0; checks = 0; cyc = 0;
    rst = 1'b0;
    hz.issue_valid = 0; hz.rs1D = '0; hz.rs2D = '0; hz.rdD = '0;
    hz.regwriteD = 0; hz.loadD = 0; hz.pcsrcE = 0; hz.mem_busy = 0;
    clear_model();

    // Reset state, with busy/branch inputs that must be masked while in reset.
    step(0, 1, 3, 4, 5, 1, 1, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    nop(2);

    // Forwarding distance walks 1, 2, 3, 0 behind an add to x5.
    step(1, 1, 0, 0, 5, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 5, 0, 0, 0, 0, 0, 0);
    nop(3);

    // Load into x6 then a use on rs2: one stall, then forward from M.
    step(1, 1, 0, 0, 6, 1, 1, 0, 0);
    step(1, 1, 0, 6, 0, 0, 0, 0, 0);
    step(1, 1, 0, 6, 0, 0, 0, 0, 0);
    nop(3);

    // Load-use coincident with a taken branch: flush wins, E gets a bubble.
    step(1, 1, 0, 0, 6, 1, 1, 0, 0);
    step(1, 1, 6, 0, 8, 1, 0, 1, 0);
    step(1, 1, 6, 8, 0, 0, 0, 0, 0);
    nop(3);

    // Three frozen cycles with a pending branch, then the flush on release.
    step(1, 1, 0, 0, 7, 1, 1, 0, 0);
    step(1, 1, 0, 0, 9, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 9, 7, 0, 0, 0, 1, 1);
    step(1, 1, 9, 7, 0, 0, 0, 1, 0);
    step(1, 1, 9, 7, 0, 0, 0, 0, 0);
    nop(3);

    // x0 never forwards and never causes a load-use stall.
    step(1, 1, 0, 0, 0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0, 1, 1, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    nop(3);

    // Twenty load-use stalls to saturate the 4-bit counters.
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 0, 0, 6, 1, 1, 0, 0);
      step(1, 1, 0, 6, 0, 0, 0, 0, 0);
      step(1, 1, 0, 6, 0, 0, 0, 0, 0);
    end
    // Reset asserted in the middle of a load-use stall.
    step(1, 1, 0, 0, 6, 1, 1, 0, 0);
    step(0, 1, 0, 6, 0, 0, 0, 0, 0);
    step(0, 1, 0, 6, 0, 0, 0, 0, 0);
    step(1, 1, 0, 6, 0, 0, 0, 0, 0);
    nop(3);

    // Randomized traffic; decode holds while stalled and a branch holds across a freeze.
    iv = 0; r1 = 0; r2 = 0; rd = 0; rw = 0; ld = 0; prev_mb = 0; prev_pc = 0;
    for (int i = 0; i < 900; i++) begin
      if (!m_last_stall) begin
        iv = ($urandom_range(0, 9) < 8);
        r1 = $urandom_range(0, 7);
        r2 = $urandom_range(0, 7);
        rd = $urandom_range(0, 7);
        rw = ($urandom_range(0, 9) < 7);
        ld = ($urandom_range(0, 9) < 3);
      end
      mb = ($urandom_range(0, 9) == 0) || (prev_mb && ($urandom_range(0, 1) == 1));
      pc = prev_mb ? prev_pc : ($urandom_range(0, 9) == 0);
      rn = ($urandom_range(0, 149) != 0);
      step(rn, iv, r1, r2, rd, rw, ld, pc, mb);
      prev_mb = mb && rn;
      prev_pc = pc;
    end
    nop(2);

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt++;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expected cycles never sampled, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
